mem_access_unit: RTL

//  Load/store initiator driving the data port (port 2) of the main memory: addr2/d22/we2/wstrb out, q2 in.

---
 rtl/mem_access_pkg.sv | 58 +++++
 rtl/mem_load_format.sv | 39 +++
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Package: mem_access_pkg
// Shared types and helpers for the load/store initiator.
//  state_t   : FSM states (IDLE, ISSUE, HOLD, CAPT, RESP)
//  F3_*      : RV32I funct3 encodings for loads/stores
//  size_t    : access size decoded from funct3[1:0] (11 is treated as word)
//  size_of   : funct3 -> size
//  gen_strb  : size + address low bits -> byte strobes
//  lane_data : size + LSB-aligned store data -> lane-replicated bus data
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    HOLD  = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // funct3[2] only selects sign/zero extension, so the size comes from [1:0].
  function automatic size_t size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = SZ_B;
      2'b01:   size_of = SZ_H;
      default: size_of = SZ_W;
    endcase
  endfunction

  // Address bits below the access size are ignored (a half uses only lo[1]).
  function automatic logic [3:0] gen_strb(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    gen_strb = 4'b0001 << lo;
      SZ_H:    gen_strb = lo[1] ? 4'b1100 : 4'b0011;
      default: gen_strb = 4'b1111;
    endcase
  endfunction

  // Replicate the store value on every lane so the strobe alone picks the target.
  function automatic logic [31:0] lane_data(input size_t sz, input logic [31:0] d);
    case (sz)
      SZ_B:    lane_data = {4{d[7:0]}};
      SZ_H:    lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_format.sv
// Module: mem_load_format
// Combinational load formatter: picks the byte/half lane addressed by
// addr_lo from the raw memory word and sign- or zero-extends it.
//  rdata   in  32  raw word from memory
//  addr_lo in  2   byte address bits [1:0]
//  funct3  in  3   load funct3 (bit 2 set = zero-extend)
//  data    out 32  extended load result
module mem_load_format
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_en;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata[8*gi +: 8];
  end

  assign byte_sel = lane[addr_lo];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  assign sign_en  = ~funct3[2];

  always_comb begin
    data = rdata;
    case (size_of(funct3))
      SZ_B:    data = {{24{sign_en & byte_sel[7]}}, byte_sel};
      SZ_H:    data = {{16{sign_en & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Module: mem_access_unit
// Load/store initiator for the data port of the main memory. Accepts one
// RV32I load/store at a time over valid/ready, drives address, lane-replicated
// write data, write enable and byte strobes, then formats the load result and
// returns a single-cycle response.
// Optional feature: define MEM_ACCESS_TRAP_EN to flag misaligned accesses and
// illegal funct3 codes on rsp_err (no memory access is made for them).
// Parameters: ADDR_WIDTH (address width), WAIT_STATES (extra address hold
// cycles before the read data is sampled).
// Ports:
//  clk, reset                      clock, async active-high reset
//  req_valid/req_ready             request handshake (ready only in IDLE)
//  req_we/req_funct3/req_addr/req_wdata  request fields
//  rsp_valid/rsp_rdata/rsp_err     one-cycle response
//  mem_addr/mem_wdata/mem_we/mem_wstrb   memory port outputs
//  mem_rdata                       memory read data (one cycle after address)
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata
);
  import mem_access_pkg::*;

  state_t      state_reg, state_next;
  logic [2:0]  f3_reg;
  logic [1:0]  addr_lo_reg;
  logic        we_reg;
  logic        req_err;
  logic        is_err;
  logic        hold_done;
  logic [31:0] load_data;
  size_t       req_size;

  assign req_size  = size_of(req_funct3);
  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);

`ifdef MEM_ACCESS_TRAP_EN
  logic err_reg;

  // 011 and 11x are not RV32I load/store codes; unsigned variants are loads only.
  assign req_err = (req_funct3 == 3'b011)
                 || (req_funct3[2:1] == 2'b11)
                 || (req_we && req_funct3[2])
                 || ((req_size == SZ_H) && req_addr[0])
                 || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_reg <= 1'b0;
    else if (state_reg == IDLE && req_valid)
      err_reg <= req_err;
  end

  assign is_err  = err_reg;
  assign rsp_err = (state_reg == RESP) && err_reg;
`else
  assign req_err = 1'b0;
  assign is_err  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // HOLD stretches the address phase for slow memories; counter exists only
  // when there are wait states to count.
  if (WAIT_STATES > 0) begin : g_hold
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        cnt_reg <= '0;
      else if (state_reg == HOLD)
        cnt_reg <= cnt_reg + 1'b1;
      else
        cnt_reg <= '0;
    end

    assign hold_done = (cnt_reg == CW'(WAIT_STATES - 1));
  end else begin : g_nohold
    assign hold_done = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (req_valid) state_next = ISSUE;
      ISSUE: begin
        if (we_reg || is_err)
          state_next = RESP;
        else if (WAIT_STATES == 0)
          state_next = CAPT;
        else
          state_next = HOLD;
      end
      HOLD:  if (hold_done) state_next = CAPT;
      CAPT:  state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  mem_load_format u_load_format (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_reg),
    .funct3  (f3_reg),
    .data    (load_data)
  );

  // Request capture, memory port drive and response data. mem_we/mem_wstrb
  // are set on the accept edge and cleared on the edge ending ISSUE, so a
  // store writes exactly once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_reg      <= 3'b000;
      addr_lo_reg <= 2'b00;
      we_reg      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_wstrb   <= 4'b0000;
      rsp_rdata   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            f3_reg      <= req_funct3;
            addr_lo_reg <= req_addr[1:0];
            we_reg      <= req_we;
            mem_addr    <= req_addr;
            mem_wdata   <= lane_data(req_size, req_wdata);
            mem_we      <= req_we && !req_err;
            mem_wstrb   <= (req_we && !req_err) ? gen_strb(req_size, req_addr[1:0]) : 4'b0000;
          end
        end
        ISSUE: begin
          mem_we    <= 1'b0;
          mem_wstrb <= 4'b0000;
          if (we_reg || is_err)
            rsp_rdata <= '0;
        end
        CAPT: rsp_rdata <= load_data;
        default: ;
      endcase
    end
  end

endmodule
